// File: rtl/barrel_shift_pipe_if.sv
// Handshake and data bundle for barrel_shift_pipe.
// out_sticky exists only when BARREL_SHIFT_PIPE_STICKY_EN is defined.
interface barrel_shift_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic             in_dir;
    logic [1:0]       in_mode;
    logic             in_fill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    logic             out_sticky;

    modport master (
        output in_valid, in_data, in_shamt, in_dir, in_mode, in_fill, out_ready,
        input  in_ready, out_valid, out_data, out_sticky
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, in_mode, in_fill, out_ready,
        output in_ready, out_valid, out_data, out_sticky
    );
`else
    modport master (
        output in_valid, in_data, in_shamt, in_dir, in_mode, in_fill, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, in_mode, in_fill, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator, one power-of-two shift level per stage, valid/ready both sides.
// Optional sticky output (OR of shifted-out bits) enabled by BARREL_SHIFT_PIPE_STICKY_EN.
module barrel_shift_pipe #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    barrel_shift_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int L   = SHW;

    // Applies one shift/rotate step of amt positions.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d, input int amt,
                                                    input logic dir, input logic [1:0] mode,
                                                    input logic fill);
        logic [WIDTH-1:0] r;
        logic [SHW-1:0]   src;
        logic             f;
        f = (mode == 2'b01) ? (!dir && d[WIDTH-1]) : fill;
        for (int i = 0; i < WIDTH; i++) begin
            src = dir ? SHW'(i) - SHW'(amt) : SHW'(i) + SHW'(amt);
            if (mode[1] || (dir ? (i >= amt) : (i + amt < WIDTH))) r[i] = d[src];
            else r[i] = f;
        end
        return r;
    endfunction

`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    function automatic logic sticky_step(input logic [WIDTH-1:0] d, input int amt,
                                         input logic dir, input logic [1:0] mode);
        logic s;
        s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dir ? (i >= WIDTH - amt) : (i < amt)) s = s | d[i];
        end
        return s && !mode[1];
    endfunction

    logic [L-1:0] sticky_q, sticky_d;
`endif

    logic [L-1:0]     v_q, v_d;
    logic [L-1:0]     ready;
    logic [WIDTH-1:0] data_q  [L];
    logic [WIDTH-1:0] data_d  [L];
    // The last stage only presents results, so control stops one stage short.
    logic [SHW-1:0]   shamt_q [L-1];
    logic [SHW-1:0]   shamt_d [L-1];
    logic             dir_q   [L-1];
    logic             dir_d   [L-1];
    logic [1:0]       mode_q  [L-1];
    logic [1:0]       mode_d  [L-1];
    logic             fill_q  [L-1];
    logic             fill_d  [L-1];

    always_comb begin
        v_d     = v_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
        sticky_d = sticky_q;
`endif
        // Stage k may load when the sink is ready or some stage at or after k is empty.
        for (int k = 0; k < L; k++) begin
            ready[k] = bus.out_ready || (|(~v_q & ({L{1'b1}} << k)));
        end

        if (ready[0]) v_d[0] = bus.in_valid;
        if (ready[0] && bus.in_valid) begin
            data_d[0]  = bus.in_shamt[0] ?
                         shift_step(bus.in_data, 1, bus.in_dir, bus.in_mode, bus.in_fill) :
                         bus.in_data;
            shamt_d[0] = bus.in_shamt;
            dir_d[0]   = bus.in_dir;
            mode_d[0]  = bus.in_mode;
            fill_d[0]  = bus.in_fill;
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
            sticky_d[0] = bus.in_shamt[0] &&
                          sticky_step(bus.in_data, 1, bus.in_dir, bus.in_mode);
`endif
        end

        for (int k = 1; k < L; k++) begin
            if (ready[k]) v_d[k] = v_q[k-1];
            if (ready[k] && v_q[k-1]) begin
                data_d[k] = shamt_q[k-1][k] ?
                            shift_step(data_q[k-1], 1 << k, dir_q[k-1], mode_q[k-1],
                                       fill_q[k-1]) :
                            data_q[k-1];
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
                sticky_d[k] = sticky_q[k-1] || (shamt_q[k-1][k] &&
                              sticky_step(data_q[k-1], 1 << k, dir_q[k-1], mode_q[k-1]));
`endif
            end
        end

        for (int k = 1; k < L - 1; k++) begin
            if (ready[k] && v_q[k-1]) begin
                shamt_d[k] = shamt_q[k-1];
                dir_d[k]   = dir_q[k-1];
                mode_d[k]  = mode_q[k-1];
                fill_d[k]  = fill_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < L; k++) data_q[k] <= '0;
            for (int k = 0; k < L - 1; k++) begin
                shamt_q[k] <= '0;
                dir_q[k]   <= 1'b0;
                mode_q[k]  <= 2'b00;
                fill_q[k]  <= 1'b0;
            end
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
            sticky_q <= '0;
`endif
        end else begin
            v_q     <= v_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign bus.in_ready  = ready[0] && !rst;
    assign bus.out_valid = v_q[L-1];
    assign bus.out_data  = data_q[L-1];
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    assign bus.out_sticky = sticky_q[L-1];
`endif
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe (WIDTH=8) against an arithmetic reference model.
module tb_barrel_shift_pipe;
    localparam int W = 8;
    localparam int L = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    barrel_shift_pipe_if #(.WIDTH(W)) bus ();
    barrel_shift_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {sticky, data} computed from the shift rules with plain operators.
    function automatic logic [W:0] model(input logic [W-1:0] d, input int s, input logic dir,
                                         input logic [1:0] mode, input logic fill);
        logic [W-1:0] ones;
        logic [W-1:0] r;
        logic         st;
        ones = '1;
        if (mode[1]) begin
            r  = dir ? ((d << s) | (d >> (W - s))) : ((d >> s) | (d << (W - s)));
            st = 1'b0;
        end else if (!dir) begin
            if (mode == 2'b01) r = $signed(d) >>> s;
            else r = (d >> s) | (fill ? ~(ones >> s) : '0);
            st = |(d & ~(ones << s));
        end else begin
            r  = (d << s) | ((mode == 2'b00 && fill) ? ~(ones << s) : '0);
            st = |(d & ~(ones >> s));
        end
        return {st, r};
    endfunction

    task automatic drive(input logic [W-1:0] d, input logic [2:0] s, input logic dir,
                         input logic [1:0] mode, input logic fill);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_dir   = dir;
        bus.in_mode  = mode;
        bus.in_fill  = fill;
    endtask

    task automatic drive_random(input logic zero_shift);
        drive(W'($urandom), zero_shift ? 3'd0 : 3'($urandom_range(0, 7)), 1'($urandom),
              2'($urandom), 1'($urandom));
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(8'hFF, 3'd1, 1'b0, 2'b00, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        if (bus.out_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_out_data: got %h want 00", bus.out_data);
        end
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
        n_checks++;
        if (bus.out_sticky !== 1'b0) begin
            n_fail++; $display("FAIL reset_sticky: got %b want 0", bus.out_sticky);
        end
`endif
        // Idle data on the input must not leak to out_data.
        for (int i = 0; i < 4; i++) begin
            bus.in_data = W'($urandom) | 8'h01;
            @(negedge clk);
            n_checks++;
            if (bus.out_data !== 8'h00 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_out: got valid %b data %h want 0 00", bus.out_valid,
                         bus.out_data);
            end
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] vd [6] = '{8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'hB4};
        logic [2:0]   vs [6] = '{3'd3, 3'd2, 3'd1, 3'd3, 3'd4, 3'd0};
        logic         vr [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0]   vm [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
        logic         vf [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] ve [6] = '{8'h16, 8'hED, 8'h69, 8'hA5, 8'h4B, 8'hB4};
        logic         vk [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            @(posedge clk);
            #1 drive(vd[v], vs[v], vr[v], vm[v], vf[v]);
            @(negedge clk);
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL dir_in_ready[%0d]: got %b want 1", v, bus.in_ready);
            end
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            for (int c = 1; c <= L; c++) begin
                @(negedge clk);
                n_checks++;
                if (bus.out_valid !== (c == L)) begin
                    n_fail++;
                    $display("FAIL dir_latency[%0d] cycle %0d: got %b want %b", v, c,
                             bus.out_valid, c == L);
                end
            end
            n_checks++;
            if (bus.out_data !== ve[v]) begin
                n_fail++; $display("FAIL dir_data[%0d]: got %h want %h", v, bus.out_data, ve[v]);
            end
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
            n_checks++;
            if (bus.out_sticky !== vk[v]) begin
                n_fail++;
                $display("FAIL dir_sticky[%0d]: got %b want %b", v, bus.out_sticky, vk[v]);
            end
`endif
        end
    endtask

    task automatic test_back_pressure;
        logic [W:0]   exp [$];
        logic [W:0]   want;
        logic [W-1:0] wd [5];
        logic [2:0]   ws [5];
        logic         wr [5];
        logic [1:0]   wm [5];
        logic         wf [5];
        int           idx, acc, got;
        int           got_cyc [5];
        logic         took;
        for (int i = 0; i < 5; i++) begin
            wd[i] = W'($urandom); ws[i] = 3'($urandom); wr[i] = 1'($urandom);
            wm[i] = 2'($urandom); wf[i] = 1'($urandom);
        end
        idx = 0; acc = 0; got = 0;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        drive(wd[0], ws[0], wr[0], wm[0], wf[0]);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            if (took) begin
                exp.push_back(model(wd[idx], int'(ws[idx]), wr[idx], wm[idx], wf[idx]));
                acc++;
            end
            @(posedge clk);
            #1 if (took) begin
                idx++;
                drive(wd[idx], ws[idx], wr[idx], wm[idx], wf[idx]);
            end
        end
        @(negedge clk);
        n_checks += 3;
        if (acc != 3) begin
            n_fail++; $display("FAIL bp_accepted: got %0d want 3", acc);
        end
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready_full: got %b want 0", bus.in_ready);
        end
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_out_valid_held: got %b want 1", bus.out_valid);
        end
        bus.out_ready = 1'b1;
        #1;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                want = (exp.size() > 0) ? exp.pop_front() : {1'b0, ~bus.out_data};
                n_checks++;
                if (bus.out_data !== want[W-1:0]) begin
                    n_fail++;
                    $display("FAIL bp_data[%0d]: got %h want %h", got, bus.out_data, want[W-1:0]);
                end
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
                n_checks++;
                if (bus.out_sticky !== want[W]) begin
                    n_fail++;
                    $display("FAIL bp_sticky[%0d]: got %b want %b", got, bus.out_sticky, want[W]);
                end
`endif
                got_cyc[got] = c;
                got++;
            end
            took = bus.in_valid && bus.in_ready;
            if (took) exp.push_back(model(wd[idx], int'(ws[idx]), wr[idx], wm[idx], wf[idx]));
            @(posedge clk);
            #1 if (took) begin
                idx++;
                if (idx < 5) drive(wd[idx], ws[idx], wr[idx], wm[idx], wf[idx]);
                else bus.in_valid = 1'b0;
            end
        end
        n_checks += 4;
        if (got != 5) begin
            n_fail++; $display("FAIL bp_count: got %0d want 5", got);
        end
        if (got >= 3 && (got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1)) begin
            n_fail++;
            $display("FAIL bp_consecutive: got cycles %0d %0d %0d want consecutive",
                     got_cyc[0], got_cyc[1], got_cyc[2]);
        end
        if (exp.size() != 0) begin
            n_fail++; $display("FAIL bp_leftover: got %0d pending want 0", exp.size());
        end
        @(negedge clk);
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_duplicate: got out_valid %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_stream;
        logic [W:0] exp [$];
        logic [W:0] want;
        int         sent, got, prev;
        logic       took;
        sent = 0; got = 0; prev = -1;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drive_random(1'b1);
        for (int c = 0; c < 60 && got < 16; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                want = (exp.size() > 0) ? exp.pop_front() : {1'b0, ~bus.out_data};
                n_checks++;
                if (bus.out_data !== want[W-1:0]) begin
                    n_fail++;
                    $display("FAIL stream_data[%0d]: got %h want %h", got, bus.out_data,
                             want[W-1:0]);
                end
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
                n_checks++;
                if (bus.out_sticky !== want[W]) begin
                    n_fail++;
                    $display("FAIL stream_sticky[%0d]: got %b want %b", got, bus.out_sticky,
                             want[W]);
                end
`endif
                if (prev >= 0) begin
                    n_checks++;
                    if (c != prev + 1) begin
                        n_fail++;
                        $display("FAIL stream_rate[%0d]: got cycle %0d want %0d", got, c, prev + 1);
                    end
                end
                prev = c;
                got++;
            end
            took = bus.in_valid && bus.in_ready;
            if (took) begin
                if (bus.in_shamt == 3'd0) exp.push_back({1'b0, bus.in_data});
                else exp.push_back(model(bus.in_data, int'(bus.in_shamt), bus.in_dir,
                                         bus.in_mode, bus.in_fill));
                sent++;
            end
            @(posedge clk);
            #1 if (took) begin
                if (sent < 16) drive_random(sent % 4 == 0);
                else bus.in_valid = 1'b0;
            end
        end
        n_checks++;
        if (got != 16) begin
            n_fail++; $display("FAIL stream_count: got %0d want 16", got);
        end
    endtask

    task automatic test_reset_midflight;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drive(8'h81, 3'd1, 1'b0, 2'b00, 1'b1);
        @(posedge clk);
        #1 drive(8'h3C, 3'd2, 1'b1, 2'b10, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(8'hF0, 3'd0, 1'b0, 2'b00, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_out_valid: got %b want 0", bus.out_valid);
        end
        if (bus.out_data !== 8'h00) begin
            n_fail++; $display("FAIL mid_rst_out_data: got %h want 00", bus.out_data);
        end
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_rst_in_ready: got %b want 1", bus.in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
                n_fail++;
                $display("FAIL mid_rst_stale[%0d]: got valid %b data %h want 0 00", i,
                         bus.out_valid, bus.out_data);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_dir    = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_fill   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_pressure();
        test_stream();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
